// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared types and header field positions for the SPU frame assembler
package spu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_e;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int LEN_MSB = 3;
    localparam int LEN_LSB = 0;

    // Sticky error update: a clear empties the register, and a new error is
    // only recorded when the register is empty after that clear.
    function automatic err_e err_merge(input err_e cur, input logic clr, input err_e new_err);
        err_e nxt;
        nxt = clr ? ERR_NONE : cur;
        if (new_err != ERR_NONE && nxt == ERR_NONE) begin
            nxt = new_err;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spu_strobe_sync.sv
// rtl/spu_strobe_sync.sv - two-flop strobe synchronizer with rising-edge pulse
module spu_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Synchronizer chain plus one extra stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/spu_frame_assembler.sv
// rtl/spu_frame_assembler.sv - assembles header and operand bytes into SPU command frames
module spu_frame_assembler
    import spu_pkg::*;
#(
    parameter int MAX_OPS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_byte,
    input  logic                 in_strobe,
    input  logic                 err_clr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [3:0]           cmd_op,
    output logic [3:0]           cmd_len,
    output logic [8*MAX_OPS-1:0] cmd_data,
    output logic                 busy,
    output logic [1:0]           err_code
);

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam int              DW       = 8 * MAX_OPS;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]      MAX_LEN  = 4'(MAX_OPS);

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      idx_q, idx_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    err_e            err_q, err_d;
    err_e            new_err;
    logic            byte_evt;
    logic [3:0]      hdr_op;
    logic [3:0]      hdr_len;

    spu_strobe_sync u_strobe_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (in_strobe),
        .pulse_o (byte_evt)
    );

    assign hdr_op  = in_byte[OP_MSB:OP_LSB];
    assign hdr_len = in_byte[LEN_MSB:LEN_LSB];

    // Frame FSM next-state, datapath and error detection
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tmo_d   = '0;
        new_err = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (byte_evt) begin
                    op_d   = hdr_op;
                    len_d  = hdr_len;
                    data_d = '0;
                    idx_d  = '0;
                    if (hdr_len == 4'd0) begin
                        state_d = ST_HOLD;
                    end else if (hdr_len > MAX_LEN) begin
                        new_err = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_evt) begin
                    for (int k = 0; k < MAX_OPS; k++) begin
                        if (idx_q == 4'(k)) begin
                            data_d[8*k +: 8] = in_byte;
                        end
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q + 4'd1 == len_q) begin
                        state_d = ST_HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Stalled frame: drop the partial payload, keep op/len
                    new_err = ERR_TIMEOUT;
                    data_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (byte_evt) begin
                    new_err = ERR_OVERRUN;
                end
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = err_merge(err_q, err_clr, new_err);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign cmd_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_op    = op_q;
    assign cmd_len   = len_q;
    assign cmd_data  = data_q;
    assign err_code  = err_q;

endmodule
